// File: rtl/tick_timer_pkg.sv
// Shared types and defaults for the tick timer and its edge detector.
package tick_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int WIDTH_DEF = 16;

endpackage

// File: rtl/tick_timer_rise_detect.sv
// Registered rising-edge pulse for a signal already synchronous to clk_in.
// rise is the same-cycle (unregistered) edge, pulse is its registered copy.
module rise_detect (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic pulse,
  output logic rise
);

  logic q;

  assign rise = d & ~q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      q     <= 1'b0;
      pulse <= 1'b0;
    end else begin
      q     <= d;
      pulse <= rise;
    end
  end

endmodule

// File: rtl/tick_timer.sv
// Loadable down-counter clocked by rising edges of the divided clock,
// with start/stop control, one-shot or auto-reload mode and a done pulse.
module tick_timer
  import tick_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             div_clk,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic             mode;
  logic             tick_int;

  rise_detect u_rise (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (div_clk),
    .pulse  (tick),
    .rise   (tick_int)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A tick coinciding with an accepted start is deliberately not counted.
          if (start) begin
            if (load_val != '0) begin
              count  <= load_val;
              reload <= load_val;
              mode   <= periodic;
              state  <= ST_RUN;
              busy   <= 1'b1;
            end else begin
              count <= '0;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // stop has priority over both a tick and a (ignored) start.
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else if (tick_int) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else if (count == ONE) begin
              done <= 1'b1;
              if (mode) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
